// File: rtl/debug_exec_ctrl.sv
// debug_exec_ctrl: UART-driven load/run/step controller for the MIPS pipeline (optional watchdog: CYCLE_LIMIT_EN)
module debug_exec_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_ADDR = 10,
    parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF
`ifdef CYCLE_LIMIT_EN
    ,
    parameter logic [NB_DATA-1:0] MAX_CYCLES = 32'd1024
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_instruction,
    output logic               o_valid,
    output logic               o_pipe_reset,
    output logic               o_imem_wr_en,
    output logic [NB_ADDR-1:0] o_imem_wr_addr,
    output logic [NB_DATA-1:0] o_imem_wr_data,
    output logic               o_halted,
    output logic               o_load_ovf,
    output logic [NB_DATA-1:0] o_cycle_count,
`ifdef CYCLE_LIMIT_EN
    output logic               o_timeout,
`endif
    output logic [2:0]         o_state
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [NB_BYTE-1:0] CMD_L = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_C = 8'h43;
    localparam logic [NB_BYTE-1:0] CMD_S = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_N = 8'h4E;
    localparam logic [NB_BYTE-1:0] CMD_E = 8'h45;
    localparam logic [NB_BYTE-1:0] CMD_R = 8'h52;

    logic [2:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic               pipe_reset_q, pipe_reset_d;
    logic               halted_q, halted_d;
    logic               ovf_q, ovf_d;
    logic               wr_en_q, wr_en_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic [NB_DATA-1:0] count_q, count_d, count_inc;
    logic [1:0]         nbyte_q, nbyte_d;
    logic [NB_DATA-1:0] word;
    logic rx_l, rx_c, rx_s, rx_n, rx_e, rx_r;
    logic load_start, start, abort, halt_hit, word_done, timeout_hit;

    assign rx_l = i_rx_done && i_rx_data == CMD_L;
    assign rx_c = i_rx_done && i_rx_data == CMD_C;
    assign rx_s = i_rx_done && i_rx_data == CMD_S;
    assign rx_n = i_rx_done && i_rx_data == CMD_N;
    assign rx_e = i_rx_done && i_rx_data == CMD_E;
    assign rx_r = i_rx_done && i_rx_data == CMD_R;

    assign load_start = state_q == S_IDLE && rx_l;
    assign start      = (state_q == S_IDLE || state_q == S_DONE) && (rx_c || rx_s);
    assign abort      = rx_r && state_q inside {S_RUN, S_STEP, S_DONE};
    assign halt_hit   = state_q inside {S_RUN, S_STEP} && valid_q && i_instruction == HALT_INSTR;
    assign word       = {data_q[NB_DATA-NB_BYTE-1:0], i_rx_data};
    assign word_done  = state_q == S_LOAD && i_rx_done && nbyte_q == 2'd3;
    assign count_inc  = (valid_q && count_q != '1) ? count_q + NB_DATA'(1) : count_q;

`ifdef CYCLE_LIMIT_EN
    logic timeout_q, timeout_d;
    assign timeout_hit = state_q == S_RUN && valid_q && count_inc == MAX_CYCLES;
    assign timeout_d   = start ? 1'b0 : (timeout_hit && !halt_hit && !abort) || timeout_q;
    always_ff @(posedge i_clock) begin
        if (i_reset) timeout_q <= 1'b0;
        else timeout_q <= timeout_d;
    end
    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = rx_l ? S_LOAD : rx_c ? S_RUN : rx_s ? S_STEP : S_IDLE;
            S_LOAD:  state_d = (word_done && word == HALT_INSTR) ? S_IDLE : S_LOAD;
            S_RUN:   state_d = abort ? S_IDLE : (halt_hit || timeout_hit) ? S_DONE : S_RUN;
            S_STEP:  state_d = abort ? S_IDLE : halt_hit ? S_DONE : rx_e ? S_IDLE : S_STEP;
            S_DONE:  state_d = abort ? S_IDLE : rx_c ? S_RUN : rx_s ? S_STEP : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // A step pulse only launches from a quiet cycle, so a repeated 'N' during the pulse is dropped
    always_comb begin
        valid_d      = state_d == S_RUN || (state_q == S_STEP && state_d == S_STEP && rx_n && !valid_q);
        pipe_reset_d = abort;
        halted_d     = start ? 1'b0 : (halt_hit && !abort) || halted_q;
        count_d      = start ? '0 : count_inc;
        nbyte_d      = load_start ? 2'd0 : (state_q == S_LOAD && i_rx_done) ? nbyte_q + 2'd1 : nbyte_q;
        data_d       = (state_q == S_LOAD && i_rx_done) ? word : data_q;
        wr_en_d      = word_done;
        addr_d       = load_start ? '0 : wr_en_q ? addr_q + NB_ADDR'(1) : addr_q;
        ovf_d        = load_start ? 1'b0 : (wr_en_q && addr_q == '1) || ovf_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q      <= 1'b0;
            pipe_reset_q <= 1'b0;
            halted_q     <= 1'b0;
            ovf_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            count_q      <= '0;
            nbyte_q      <= 2'd0;
        end else begin
            valid_q      <= valid_d;
            pipe_reset_q <= pipe_reset_d;
            halted_q     <= halted_d;
            ovf_q        <= ovf_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            count_q      <= count_d;
            nbyte_q      <= nbyte_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_pipe_reset   = pipe_reset_q;
    assign o_imem_wr_en   = wr_en_q;
    assign o_imem_wr_addr = addr_q;
    assign o_imem_wr_data = data_q;
    assign o_halted       = halted_q;
    assign o_load_ovf     = ovf_q;
    assign o_cycle_count  = count_q;
    assign o_state        = state_q;
endmodule
